sprite_layer_display: RTL and testbench

//  Parametrised sprite-layer renderer for the VGA path: holds CHILD_LIMIT sprite instances of one sub-component in

---
 rtl/sprite_pkg.sv | 77 +++++++
 rtl/sprite_addr_gen.sv | 33 +++
 rtl/sprite_layer_display.sv | 221 ++++++++++++++++++++++
 tb/tb_sprite_layer_display.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types, pattern tables, palette and ROM image for the sprite layer.
// The ROM image is generated here by a pure function rather than loaded from
// a file, so the same image is available to synthesis and simulation.
package sprite_pkg;

    typedef enum logic [3:0] {
        INFO_FIELD = 4'h1,
        INFO_SWAP  = 4'hF
    } info_e;

    typedef enum logic [2:0] {
        TYPE_ATTR  = 3'b001,
        TYPE_X     = 3'b010,
        TYPE_Y     = 3'b011,
        TYPE_SHIFT = 3'b100
    } field_e;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    // Command bus word layout.
    typedef struct packed {
        logic [5:0]  sub_comp;
        logic [4:0]  child;
        logic [3:0]  info;
        logic [2:0]  typ;
        logic        pp_selc;
        logic [12:0] msg;
    } cmd_t;

    typedef struct packed {
        logic [15:0] base;
        logic [15:0] width;
        logic [15:0] height;
    } pattern_t;

    // Per-child state held in each bank.
    typedef struct packed {
        logic       vis;
        logic       flip;
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] shift;
        logic [4:0] pattern;
    } sprite_state_t;

    localparam int PAT_COUNT = 2;

    // Pattern 0: 16x16 at pixel 0; pattern 1: 8x16 at pixel 256.
    localparam pattern_t PAT_TABLE [PAT_COUNT] = '{
        '{16'd0,   16'd16, 16'd16},
        '{16'd256, 16'd8,  16'd16}
    };

    // Index 0 is transparent and never displayed.
    localparam logic [23:0] PALETTE [4] = '{
        24'h000000, 24'hff0000, 24'h00ff00, 24'h0000ff
    };

    // Out-of-range pattern codes map to a zero-size box that never hits.
    function automatic pattern_t get_pattern(input logic [4:0] code);
        pattern_t r;
        r = '0;
        for (int i = 0; i < PAT_COUNT; i++) begin
            if (int'(code) == i) r = PAT_TABLE[i];
        end
        return r;
    endfunction

    // 4-bit ROM word (two 2-bpp pixels) at word address word_addr.
    function automatic logic [3:0] rom_word(input logic [14:0] word_addr);
        return 4'(word_addr * 15'd5 + 15'd3 + (word_addr >> 3));
    endfunction

endpackage

// File: rtl/sprite_addr_gen.sv
// Per-child lane: box test against the current pixel and ROM pixel address.
module sprite_addr_gen
    import sprite_pkg::*;
#(
    parameter logic [15:0] ADDR_LIMIT = 16'd384
) (
    input  sprite_state_t st,
    input  logic [9:0]    hcount,
    input  logic [9:0]    vcount,
    output logic [15:0]   addr,
    output logic          hit
);

    pattern_t    pat;
    logic [15:0] dx;
    logic [15:0] dy;
    logic [15:0] col;
    logic        in_x;
    logic        in_y;

    // Offsets are only meaningful once hcount>=x / vcount>=y, which the box test checks first.
    always_comb begin
        pat  = get_pattern(st.pattern);
        dx   = {6'b0, hcount} - {6'b0, st.x};
        dy   = {6'b0, vcount} - {6'b0, st.y};
        in_x = (hcount >= st.x) && (dx < pat.width);
        in_y = (vcount >= st.y) && (dy < pat.height);
        col  = st.flip ? (pat.width - 16'd1 - dx) : dx;
        addr = pat.base + (dy * pat.width) + col + {6'b0, st.shift};
        hit  = st.vis && in_x && in_y && (addr < ADDR_LIMIT);
    end

endmodule

// File: rtl/sprite_layer_display.sv
// Sprite layer renderer: ping/pong state banks written over the command bus,
// frame-synchronised bank swap, 2-stage pixel pipeline.
// Optional macro SPRITE_COLLISION_EN adds the sticky sprite-overlap flag;
// without it the collision port is tied low.
//
// Swap FSM
//   state        | meaning
//   SWAP_IDLE    | no swap waiting; a request on the swap cycle applies at once
//   SWAP_PENDING | swap to sel_q waits for vcount==SWAP_LINE, hcount==0
module sprite_layer_display
    import sprite_pkg::*;
#(
    parameter logic [5:0]  SUB_COMP_ID = 6'd5,
    parameter int          CHILD_LIMIT = 4,
    parameter int          PATTERN_NUM = 2,
    parameter logic [15:0] ADDR_LIMIT  = 16'd384,
    parameter logic [9:0]  SWAP_LINE   = 10'd480,
    parameter logic [23:0] BG_COLOR    = 24'h9290ff
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    output logic [23:0] RGB_output,
    output logic        collision
);

    cmd_t          cmd;
    logic          swap_req;
    logic          field_wr;
    logic          swap_point;
    logic          unused_msg_bit;

    swap_state_e   state_q, state_d;
    logic          sel_q, sel_d;
    logic          apply;
    logic          apply_sel;

    sprite_state_t bank [2][CHILD_LIMIT];
    logic          active;

    logic [15:0]   lane_addr [CHILD_LIMIT];
    logic          lane_hit  [CHILD_LIMIT];
    logic [15:0]   s1_addr   [CHILD_LIMIT];
    logic          s1_hit    [CHILD_LIMIT];

    logic [3:0]             word;
    logic [1:0]             idx;
    logic [CHILD_LIMIT-1:0] opaque;
    logic                   found;
    logic [23:0]            px_color;

    assign cmd            = cmd_t'(writedata);
    assign swap_req       = write && (cmd.info == INFO_SWAP);
    assign field_wr       = write && (cmd.info == INFO_FIELD) && (cmd.sub_comp == SUB_COMP_ID)
                            && (int'(cmd.child) < CHILD_LIMIT);
    assign swap_point     = (vcount == SWAP_LINE) && (hcount == 10'd0);
    // msg[10] carries no field for any command type.
    assign unused_msg_bit = cmd.msg[10];

    // Swap FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= SWAP_IDLE;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
        end
    end

    // Swap FSM next state; a request landing on the swap cycle wins over an older one.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        apply     = 1'b0;
        apply_sel = sel_q;
        case (state_q)
            SWAP_IDLE: begin
                if (swap_req) begin
                    if (swap_point) begin
                        apply     = 1'b1;
                        apply_sel = cmd.pp_selc;
                    end else begin
                        state_d = SWAP_PENDING;
                        sel_d   = cmd.pp_selc;
                    end
                end
            end
            SWAP_PENDING: begin
                if (swap_point) begin
                    apply     = 1'b1;
                    apply_sel = swap_req ? cmd.pp_selc : sel_q;
                    state_d   = SWAP_IDLE;
                end else if (swap_req) begin
                    sel_d = cmd.pp_selc;
                end
            end
            default: state_d = SWAP_IDLE;
        endcase
    end

    // Bank state: field writes, then swap clear of the retiring bank (clear wins on vis).
    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < CHILD_LIMIT; c++) begin
                    bank[b][c] <= '0;
                end
            end
        end else begin
            for (int c = 0; c < CHILD_LIMIT; c++) begin
                if (field_wr && (int'(cmd.child) == c)) begin
                    case (cmd.typ)
                        TYPE_ATTR: begin
                            bank[cmd.pp_selc][c].vis  <= cmd.msg[12];
                            bank[cmd.pp_selc][c].flip <= cmd.msg[11];
                            if (int'(cmd.msg[4:0]) < PATTERN_NUM) begin
                                bank[cmd.pp_selc][c].pattern <= cmd.msg[4:0];
                            end
                        end
                        TYPE_X:     bank[cmd.pp_selc][c].x     <= cmd.msg[9:0];
                        TYPE_Y:     bank[cmd.pp_selc][c].y     <= cmd.msg[9:0];
                        TYPE_SHIFT: bank[cmd.pp_selc][c].shift <= cmd.msg[9:0];
                        default: ;
                    endcase
                end
            end
            if (apply) begin
                active <= apply_sel;
                for (int c = 0; c < CHILD_LIMIT; c++) begin
                    bank[~apply_sel][c].vis <= 1'b0;
                end
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CHILD_LIMIT; g++) begin : g_lane
            sprite_addr_gen #(
                .ADDR_LIMIT(ADDR_LIMIT)
            ) u_addr_gen (
                .st    (bank[active][g]),
                .hcount(hcount),
                .vcount(vcount),
                .addr  (lane_addr[g]),
                .hit   (lane_hit[g])
            );
        end
    endgenerate

    // Stage 1: register per-child address and hit.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHILD_LIMIT; c++) begin
                s1_addr[c] <= '0;
                s1_hit[c]  <= 1'b0;
            end
        end else begin
            for (int c = 0; c < CHILD_LIMIT; c++) begin
                s1_addr[c] <= lane_addr[c];
                s1_hit[c]  <= lane_hit[c];
            end
        end
    end

    // ROM lookup and priority: lowest opaque child wins.
    always_comb begin
        px_color = BG_COLOR;
        found    = 1'b0;
        opaque   = '0;
        word     = '0;
        idx      = '0;
        for (int c = 0; c < CHILD_LIMIT; c++) begin
            word      = rom_word(s1_addr[c][15:1]);
            idx       = s1_addr[c][0] ? word[3:2] : word[1:0];
            opaque[c] = s1_hit[c] && (idx != 2'd0);
            if (opaque[c] && !found) begin
                found    = 1'b1;
                px_color = PALETTE[idx];
            end
        end
    end

    // Stage 2: registered pixel output.
    always_ff @(posedge clk) begin
        if (reset) RGB_output <= BG_COLOR;
        else       RGB_output <= px_color;
    end

`ifdef SPRITE_COLLISION_EN
    logic multi_hit;
    logic coll_q;

    // Two or more opaque children on the same pixel.
    always_comb begin
        multi_hit = 1'b0;
        for (int a = 0; a < CHILD_LIMIT; a++) begin
            for (int b = a + 1; b < CHILD_LIMIT; b++) begin
                if (opaque[a] && opaque[b]) multi_hit = 1'b1;
            end
        end
    end

    // Sticky flag; a bank swap starts a fresh detection window.
    always_ff @(posedge clk) begin
        if (reset)          coll_q <= 1'b0;
        else if (apply)     coll_q <= 1'b0;
        else if (multi_hit) coll_q <= 1'b1;
    end

    assign collision = coll_q;
`else
    assign collision = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_layer_display.sv
// Self-checking bench for sprite_layer_display: directed scenarios with
// hand-computed pixel values, then random commands and pixel coordinates
// compared every cycle against a behavioural model.
module tb_sprite_layer_display;
    import sprite_pkg::*;

    localparam logic [23:0] BG = 24'h9290ff;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [9:0]  hcount = '0;
    logic [9:0]  vcount = '0;
    logic [23:0] RGB_output;
    logic        collision;

    int checks = 0;
    int errors = 0;

    sprite_layer_display dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writedata (writedata),
        .hcount    (hcount),
        .vcount    (vcount),
        .RGB_output(RGB_output),
        .collision (collision)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct {
        bit vis;
        bit flip;
        int x;
        int y;
        int shift;
        int pat;
    } mspr_t;

    mspr_t       mb [2][4];
    int          m_act;
    bit          m_pend;
    int          m_sel;
    logic [23:0] exp_s1;
    logic [23:0] exp_out;
    int          s1_n;
    bit          exp_coll;
    bit          model_ok = 0;

    function automatic void model_pixel(input int h, input int v,
                                        output logic [23:0] color, output int n);
        int base, w, ht, dx, col, a, ix;
        logic [3:0] wv;
        color = BG;
        n = 0;
        for (int c = 0; c < 4; c++) begin
            if (!mb[m_act][c].vis) continue;
            base = int'(PAT_TABLE[mb[m_act][c].pat].base);
            w    = int'(PAT_TABLE[mb[m_act][c].pat].width);
            ht   = int'(PAT_TABLE[mb[m_act][c].pat].height);
            if (h < mb[m_act][c].x || h >= mb[m_act][c].x + w) continue;
            if (v < mb[m_act][c].y || v >= mb[m_act][c].y + ht) continue;
            dx  = h - mb[m_act][c].x;
            col = mb[m_act][c].flip ? (w - 1 - dx) : dx;
            a   = (base + (v - mb[m_act][c].y) * w + col + mb[m_act][c].shift) % 65536;
            if (a >= 384) continue;
            wv = rom_word(15'(a / 2));
            ix = (a % 2 == 1) ? int'(wv[3:2]) : int'(wv[1:0]);
            if (ix == 0) continue;
            n++;
            if (n == 1) color = PALETTE[ix];
        end
    endfunction

    always @(posedge clk) begin
        logic [31:0] wd;
        bit sreq, fwr, now, apply;
        int asel, c, b, n;
        logic [23:0] col;
        if (reset) begin
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 4; j++)
                    mb[i][j] = '{0, 0, 0, 0, 0, 0};
            m_act = 0; m_pend = 0; m_sel = 0;
            exp_s1 = BG; exp_out = BG; s1_n = 0; exp_coll = 0;
            model_ok = 1;
        end else begin
            wd   = writedata;
            sreq = write && (wd[20:17] == 4'hF);
            fwr  = write && (wd[20:17] == 4'h1) && (wd[31:26] == 6'd5) && (wd[25:21] < 5'd4);
            now  = (vcount == 10'd480) && (hcount == 10'd0);
            apply = 0;
            asel  = m_sel;
            if (sreq && now) begin
                apply = 1; asel = int'(wd[13]); m_pend = 0;
            end else if (m_pend && now) begin
                apply = 1; asel = m_sel; m_pend = 0;
            end else if (sreq) begin
                m_pend = 1; m_sel = int'(wd[13]);
            end
`ifdef SPRITE_COLLISION_EN
            if (apply) exp_coll = 0;
            else if (s1_n >= 2) exp_coll = 1;
`endif
            exp_out = exp_s1;
            model_pixel(int'(hcount), int'(vcount), col, n);
            exp_s1 = col;
            s1_n   = n;
            if (fwr) begin
                c = int'(wd[25:21]);
                b = int'(wd[13]);
                case (wd[16:14])
                    3'b001: begin
                        mb[b][c].vis  = wd[12];
                        mb[b][c].flip = wd[11];
                        if (wd[4:0] < 5'd2) mb[b][c].pat = int'(wd[4:0]);
                    end
                    3'b010: mb[b][c].x     = int'(wd[9:0]);
                    3'b011: mb[b][c].y     = int'(wd[9:0]);
                    3'b100: mb[b][c].shift = int'(wd[9:0]);
                    default: ;
                endcase
            end
            if (apply) begin
                m_act = asel;
                for (int j = 0; j < 4; j++) mb[1 - asel][j].vis = 0;
            end
        end
    end

    task automatic chk(string name, logic [23:0] act, logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (model_ok && !reset) begin
            chk("rgb_model", RGB_output, exp_out);
            chk("collision_model", {23'b0, collision}, {23'b0, exp_coll});
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [31:0] mk(int sub, int child, int info, int typ, int pp, int msg);
        return {sub[5:0], child[4:0], info[3:0], typ[2:0], pp[0], msg[12:0]};
    endfunction

    task automatic step(int h, int v);
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); write = 1'b0; writedata = '0;
    endtask

    task automatic cmd_at(logic [31:0] wd, int h, int v);
        @(negedge clk);
        hcount = 10'(h); vcount = 10'(v); write = 1'b1; writedata = wd;
    endtask

    task automatic cmd(logic [31:0] wd);
        cmd_at(wd, 0, 10);
    endtask

    task automatic place(int pp, int child, int attr, int x, int y);
        cmd(mk(5, child, 1, 1, pp, attr));
        cmd(mk(5, child, 1, 2, pp, x));
        cmd(mk(5, child, 1, 3, pp, y));
    endtask

    task automatic probe(string name, int h, int v, logic [23:0] exp_rgb);
        step(h, v);
        step(h, v);
        @(negedge clk);
        #1;
        chk(name, RGB_output, exp_rgb);
    endtask

    task automatic do_reset(int n);
        @(negedge clk);
        reset = 1'b1; write = 1'b0; writedata = '0;
        repeat (n) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int r, h, v, info, typ, msg, sub;
        do_reset(3);

        // Idle after reset: background only.
        for (int i = 0; i < 20; i++) step($urandom_range(0, 639), $urandom_range(0, 479));
        @(negedge clk); #1;
        chk("reset_rgb", RGB_output, BG);
        chk("reset_coll", {23'b0, collision}, 24'h0);

        // Child 0, bank 0, pattern 0 at (100,50); swap to bank 0 at the swap line.
        place(0, 0, 1 << 12, 100, 50);
        cmd(mk(0, 0, 15, 0, 0, 0));
        step(0, 480);
        probe("t2_origin", 100, 50, 24'h0000ff);
        probe("t2_left", 99, 50, BG);
        probe("t2_right", 116, 50, BG);
        probe("t2_above", 100, 49, BG);

        // Flip shows column 15 of row 0; invalid pattern code keeps pattern 0.
        cmd(mk(5, 0, 1, 1, 0, (1 << 12) | (1 << 11)));
        probe("t3_flip", 100, 50, 24'hff0000);
        cmd(mk(5, 0, 1, 1, 0, (1 << 12) | (1 << 11) | 5));
        probe("t3_badpat", 100, 50, 24'hff0000);

        // Bank 1 child 0 pattern 1; swap requested mid-frame waits for the swap line.
        place(1, 0, (1 << 12) | 1, 100, 50);
        cmd_at(mk(0, 0, 15, 0, 1, 0), 0, 200);
        probe("t4_before", 100, 50, 24'hff0000);
        step(0, 480);
        probe("t4_after", 100, 50, 24'h0000ff);
        cmd_at(mk(0, 0, 15, 0, 0, 0), 0, 480);
        probe("t4_cleared", 100, 50, BG);

        // Overlapping opaque children: child 0 wins.
        place(0, 0, 1 << 12, 110, 55);
        place(0, 1, 1 << 12, 115, 58);
        probe("t5_overlap", 120, 60, 24'hff0000);
`ifdef SPRITE_COLLISION_EN
        chk("t5_coll", {23'b0, collision}, 24'h1);
`else
        chk("t5_coll", {23'b0, collision}, 24'h0);
`endif

        // Ignored commands.
        @(negedge clk);
        hcount = 10'd0; vcount = 10'd10; write = 1'b0; writedata = mk(5, 0, 1, 1, 0, 0);
        probe("t6_nowrite", 120, 60, 24'hff0000);
        cmd(mk(6, 0, 1, 1, 0, 0));
        probe("t6_subcomp", 120, 60, 24'hff0000);
        cmd(mk(5, 0, 2, 1, 0, 0));
        probe("t6_info", 120, 60, 24'hff0000);

        // Reset while a swap is pending discards it.
        cmd_at(mk(0, 0, 15, 0, 1, 0), 0, 10);
        do_reset(1);
        place(0, 0, 1 << 12, 100, 50);
        step(0, 480);
        probe("t6_rst_pending", 100, 50, 24'h0000ff);

        // Random phase against the model.
        for (int i = 0; i < 12000; i++) begin
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_reset(1);
                continue;
            end
            if ($urandom_range(0, 49) == 0) begin
                h = 0; v = 480;
            end else begin
                h = $urandom_range(60, 260); v = $urandom_range(20, 140);
            end
            if (r < 70) begin
                r    = $urandom_range(0, 9);
                info = (r == 0) ? 15 : (r == 1) ? int'($urandom_range(0, 15)) : 1;
                sub  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63)) : 5;
                typ  = $urandom_range(0, 5);
                case (typ)
                    1: msg = (($urandom_range(0, 4) != 0) << 12) | ($urandom_range(0, 1) << 11)
                             | $urandom_range(0, 3);
                    2: msg = $urandom_range(60, 240);
                    3: msg = $urandom_range(20, 130);
                    4: msg = ($urandom_range(0, 9) < 7) ? 0 : int'($urandom_range(0, 1023));
                    default: msg = $urandom_range(0, 8191);
                endcase
                cmd_at(mk(sub, $urandom_range(0, 5), info, typ, $urandom_range(0, 1), msg), h, v);
            end else begin
                step(h, v);
            end
        end
        repeat (4) step(0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
